// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes, status codes and sequencer state encoding for the
// tile clock-gate sequencer.
package tl_ul_pkg;

  localparam logic [2:0] A_PUT_FULL_DATA   = 3'h0;
  localparam logic [2:0] A_GET             = 3'h4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'h0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'h1;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_MISMATCH = 2'd1,
    RESP_TIMEOUT  = 2'd2,
    RESP_PROTOCOL = 2'd3
  } resp_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUT_A = 3'd1,
    ST_PUT_D = 3'd2,
    ST_GET_A = 3'd3,
    ST_GET_D = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  function automatic logic d_beat_ok(input logic [2:0]  opcode,
                                     input logic [10:0] source,
                                     input logic [2:0]  want_opcode,
                                     input logic [10:0] want_source);
    return (opcode == want_opcode) && (source == want_source);
  endfunction

endpackage

// File: rtl/cg_timeout_counter.sv
// Saturating 8-bit wait counter; expired flags the idle cycle that reaches LIMIT.
module cg_timeout_counter #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hff)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = inc && (count == (LIMIT - 8'd1));

endmodule

// File: rtl/tile_clock_gate_sequencer.sv
// TL-UL initiator that writes the tile clock-gater enable bit, reads it back,
// retries on mismatch and reports one status per request.
module tile_clock_gate_sequencer
  import tl_ul_pkg::*;
#(
  parameter logic [20:0] BASE_ADDR      = 21'h000,
  parameter logic [10:0] SOURCE_ID      = 11'h000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_enable,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_code,
  output logic        resp_state,
  output logic        busy,
  output logic        spurious_d,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [1:0]  auto_out_a_bits_size,
  output logic [10:0] auto_out_a_bits_source,
  output logic [20:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_size,
  input  logic [10:0] auto_out_d_bits_source,
  input  logic [63:0] auto_out_d_bits_data
);

  localparam logic [1:0] MAX_RETRY_COUNT = 2'(MAX_RETRIES);
  localparam logic [7:0] TIMEOUT_LIMIT   = 8'(TIMEOUT_CYCLES);

  state_e     state;
  logic       enable_latched;
  logic       put_bit;
  logic [1:0] retries;
  logic [2:0] a_opcode;
  logic       a_fire;
  logic       d_fire;
  logic       waiting;
  logic       tmo_expired;
  logic       d_ok_put;
  logic       d_ok_get;
  logic       unused_d_bits;

  assign a_fire   = auto_out_a_valid && auto_out_a_ready;
  assign d_fire   = auto_out_d_valid;
  assign waiting  = (state == ST_PUT_D) || (state == ST_GET_D);
  assign d_ok_put = d_beat_ok(auto_out_d_bits_opcode, auto_out_d_bits_source, D_ACCESS_ACK, SOURCE_ID);
  assign d_ok_get = d_beat_ok(auto_out_d_bits_opcode, auto_out_d_bits_source, D_ACCESS_ACK_DATA, SOURCE_ID);

  assign auto_out_a_bits_opcode  = a_opcode;
  assign auto_out_a_bits_param   = 3'h0;
  assign auto_out_a_bits_size    = 2'd3;
  assign auto_out_a_bits_source  = SOURCE_ID;
  assign auto_out_a_bits_address = BASE_ADDR;
  assign auto_out_a_bits_mask    = 8'h01;
  assign auto_out_a_bits_data    = {63'h0, put_bit};
  assign auto_out_a_bits_corrupt = 1'b0;
  assign auto_out_d_ready        = 1'b1;
  assign unused_d_bits           = ^{auto_out_d_bits_size, auto_out_d_bits_data[63:1]};

  // The wait counter only runs while a D beat is owed; an A fire restarts it.
  cg_timeout_counter #(.LIMIT(TIMEOUT_LIMIT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (a_fire),
    .inc     (waiting && !d_fire),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      enable_latched   <= 1'b0;
      put_bit          <= 1'b0;
      retries          <= 2'd0;
      a_opcode         <= A_PUT_FULL_DATA;
      auto_out_a_valid <= 1'b0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_code        <= RESP_OK;
      resp_state       <= 1'b0;
      busy             <= 1'b0;
      spurious_d       <= 1'b0;
    end else begin
      spurious_d <= d_fire && !waiting;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            enable_latched   <= req_enable;
            put_bit          <= req_enable;
            retries          <= 2'd0;
            resp_state       <= 1'b0;
            a_opcode         <= A_PUT_FULL_DATA;
            auto_out_a_valid <= 1'b1;
            req_ready        <= 1'b0;
            busy             <= 1'b1;
            state            <= ST_PUT_A;
          end
        end
        ST_PUT_A, ST_GET_A: begin
          if (a_fire) begin
            auto_out_a_valid <= 1'b0;
            state            <= (state == ST_PUT_A) ? ST_PUT_D : ST_GET_D;
          end
        end
        ST_PUT_D: begin
          if (d_fire) begin
            if (d_ok_put) begin
              a_opcode         <= A_GET;
              put_bit          <= 1'b0;
              auto_out_a_valid <= 1'b1;
              state            <= ST_GET_A;
            end else begin
              resp_code  <= RESP_PROTOCOL;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
          end else if (tmo_expired) begin
            resp_code  <= RESP_TIMEOUT;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_GET_D: begin
          if (d_fire) begin
            if (d_ok_get) begin
              resp_state <= auto_out_d_bits_data[0];
              if (auto_out_d_bits_data[0] == enable_latched) begin
                resp_code  <= RESP_OK;
                resp_valid <= 1'b1;
                state      <= ST_RESP;
              end else if (retries < MAX_RETRY_COUNT) begin
                retries          <= retries + 2'd1;
                a_opcode         <= A_PUT_FULL_DATA;
                put_bit          <= enable_latched;
                auto_out_a_valid <= 1'b1;
                state            <= ST_PUT_A;
              end else begin
                resp_code  <= RESP_MISMATCH;
                resp_valid <= 1'b1;
                state      <= ST_RESP;
              end
            end else begin
              resp_code  <= RESP_PROTOCOL;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
          end else if (tmo_expired) begin
            resp_code  <= RESP_TIMEOUT;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          auto_out_a_valid <= 1'b0;
          resp_valid       <= 1'b0;
          busy             <= 1'b0;
          req_ready        <= 1'b1;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
